// File: rtl/pipe_ctrl.sv
// ============================================================================
// pipe_ctrl: front/back pipeline sequencing (hazard, flush, memory freeze)
// Rev 1.0
// ============================================================================
`default_nettype none

module pipe_ctrl #(
  parameter bit FWD_EN      = 1'b0,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Two_src,
  input  logic [3:0]       src1,
  input  logic [3:0]       src2,
  input  logic [3:0]       Exe_Dest,
  input  logic             Exe_WB_EN,
  input  logic             Exe_MEM_R_EN,
  input  logic [3:0]       Mem_Dest,
  input  logic             Mem_WB_EN,
  input  logic             Mem_req,
  input  logic             mem_ready,
  input  logic             Branch_taken,
  output logic             hazard,
  output logic             freeze_front,
  output logic             flush_front,
  output logic             freeze_back,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_count
);

  localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic              exe_match;
  logic              mem_match;
  logic              dep;
  logic              mem_stall;

  assign exe_match = Exe_WB_EN && ((Exe_Dest == src1) || (Two_src && (Exe_Dest == src2)));
  assign mem_match = Mem_WB_EN && ((Mem_Dest == src1) || (Two_src && (Mem_Dest == src2)));

  // With forwarding only a load in EXE cannot be bypassed in time.
  assign dep = FWD_EN ? (exe_match && Exe_MEM_R_EN) : (exe_match || mem_match);

  assign mem_stall = ((state == ST_RUN)  && Mem_req && !mem_ready) ||
                     ((state == ST_WAIT) && !mem_ready) ||
                     (state == ST_ERR);

  always_comb begin
    state_next = state;
    case (state)
      ST_RUN: begin
        if (Mem_req && !mem_ready) state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_ready)                   state_next = ST_RUN;
        else if (wait_cnt == WAIT_LAST)  state_next = ST_ERR;
      end
      ST_ERR:  state_next = ST_ERR;
      default: state_next = ST_RUN;
    endcase
  end

  // Priority: memory freeze, then branch flush, then dependency bubble.
  always_comb begin
    hazard       = 1'b0;
    freeze_front = 1'b0;
    flush_front  = 1'b0;
    freeze_back  = 1'b0;
    if (!RST) begin
      hazard = 1'b0;
    end else if (mem_stall) begin
      freeze_front = 1'b1;
      freeze_back  = 1'b1;
    end else if (Branch_taken) begin
      flush_front = 1'b1;
    end else if (dep) begin
      hazard       = 1'b1;
      freeze_front = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= ST_RUN;
      wait_cnt    <= '0;
      mem_err     <= 1'b0;
      stall_count <= '0;
    end else begin
      state <= state_next;
      case (state)
        ST_RUN:  wait_cnt <= '0;
        ST_WAIT: if (!mem_ready) wait_cnt <= wait_cnt + WAIT_W'(1);
        default: wait_cnt <= wait_cnt;
      endcase
      if ((state == ST_WAIT) && (state_next == ST_ERR)) mem_err <= 1'b1;
      if (freeze_front && (stall_count != {CNT_W{1'b1}}))
        stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// ============================================================================
// tb_pipe_ctrl: directed self-checking bench for pipe_ctrl (two configurations)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pipe_ctrl;

  logic       CLK;
  logic       RST;
  logic       Two_src;
  logic [3:0] src1, src2, Exe_Dest, Mem_Dest;
  logic       Exe_WB_EN, Exe_MEM_R_EN, Mem_WB_EN;
  logic       Mem_req, mem_ready, Branch_taken;

  logic        a_hazard, a_freeze_front, a_flush_front, a_freeze_back, a_mem_err;
  logic [15:0] a_stall_count;
  logic        b_hazard, b_freeze_front, b_flush_front, b_freeze_back, b_mem_err;
  logic [3:0]  b_stall_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Forwarding core with default timeout and counter width.
  pipe_ctrl #(.FWD_EN(1'b1), .MEM_TIMEOUT(255), .CNT_W(16)) u_fwd (
    .CLK(CLK), .RST(RST), .Two_src(Two_src), .src1(src1), .src2(src2),
    .Exe_Dest(Exe_Dest), .Exe_WB_EN(Exe_WB_EN), .Exe_MEM_R_EN(Exe_MEM_R_EN),
    .Mem_Dest(Mem_Dest), .Mem_WB_EN(Mem_WB_EN), .Mem_req(Mem_req),
    .mem_ready(mem_ready), .Branch_taken(Branch_taken),
    .hazard(a_hazard), .freeze_front(a_freeze_front), .flush_front(a_flush_front),
    .freeze_back(a_freeze_back), .mem_err(a_mem_err), .stall_count(a_stall_count)
  );

  // No-forwarding core with short timeout and narrow counter.
  pipe_ctrl #(.FWD_EN(1'b0), .MEM_TIMEOUT(3), .CNT_W(4)) u_nofwd (
    .CLK(CLK), .RST(RST), .Two_src(Two_src), .src1(src1), .src2(src2),
    .Exe_Dest(Exe_Dest), .Exe_WB_EN(Exe_WB_EN), .Exe_MEM_R_EN(Exe_MEM_R_EN),
    .Mem_Dest(Mem_Dest), .Mem_WB_EN(Mem_WB_EN), .Mem_req(Mem_req),
    .mem_ready(mem_ready), .Branch_taken(Branch_taken),
    .hazard(b_hazard), .freeze_front(b_freeze_front), .flush_front(b_flush_front),
    .freeze_back(b_freeze_back), .mem_err(b_mem_err), .stall_count(b_stall_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    Two_src = 0; src1 = 0; src2 = 0; Exe_Dest = 0; Mem_Dest = 0;
    Exe_WB_EN = 0; Exe_MEM_R_EN = 0; Mem_WB_EN = 0;
    Mem_req = 0; mem_ready = 0; Branch_taken = 0;
  endtask

  // Ends at a falling edge with reset released.
  task automatic do_reset();
    clear_inputs();
    RST = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    check_val("rst_stall_a",  32'(a_stall_count), 0);
    check_val("rst_err_a",    32'(a_mem_err), 0);
    check_val("rst_hazard_a", 32'(a_hazard), 0);
    check_val("rst_fzb_b",    32'(b_freeze_back), 0);
    RST = 1'b1;

    // Load-use with forwarding
    Exe_Dest = 4'd3; Exe_WB_EN = 1; Exe_MEM_R_EN = 1; src1 = 4'd3;
    #1;
    check_val("lu_hazard",  32'(a_hazard), 1);
    check_val("lu_fzf",     32'(a_freeze_front), 1);
    check_val("lu_fzb",     32'(a_freeze_back), 0);
    @(negedge CLK);
    Exe_MEM_R_EN = 0;
    #1;
    check_val("lu_stall",      32'(a_stall_count), 1);
    check_val("nolu_hazard",   32'(a_hazard), 0);
    check_val("nolu_fzf",      32'(a_freeze_front), 0);
    @(negedge CLK);
    check_val("nolu_stall",    32'(a_stall_count), 1);

    // Two_src masking, no forwarding
    clear_inputs();
    Mem_Dest = 4'd5; Mem_WB_EN = 1; src2 = 4'd5; Two_src = 0;
    #1;
    check_val("ts0_hazard_b", 32'(b_hazard), 0);
    Two_src = 1;
    #1;
    check_val("ts1_hazard_b", 32'(b_hazard), 1);
    check_val("ts1_hazard_a", 32'(a_hazard), 0);

    // Branch beats dependency
    @(negedge CLK);
    do_reset();
    Exe_Dest = 4'd3; Exe_WB_EN = 1; Exe_MEM_R_EN = 1; src1 = 4'd3; Branch_taken = 1;
    #1;
    check_val("br_flush",  32'(a_flush_front), 1);
    check_val("br_hazard", 32'(a_hazard), 0);
    check_val("br_fzf",    32'(a_freeze_front), 0);
    @(negedge CLK);
    check_val("br_stall",  32'(a_stall_count), 0);
    Branch_taken = 0;
    #1;
    check_val("br_flush_end", 32'(a_flush_front), 0);

    // Memory wait of four cycles with a branch held
    @(negedge CLK);
    do_reset();
    Mem_req = 1; mem_ready = 0; Branch_taken = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_val("mw_fzf",   32'(a_freeze_front), 1);
      check_val("mw_fzb",   32'(a_freeze_back), 1);
      check_val("mw_flush", 32'(a_flush_front), 0);
      @(negedge CLK);
    end
    mem_ready = 1;
    #1;
    check_val("mw_rel_fzf",   32'(a_freeze_front), 0);
    check_val("mw_rel_fzb",   32'(a_freeze_back), 0);
    check_val("mw_rel_flush", 32'(a_flush_front), 1);
    check_val("mw_stall",     32'(a_stall_count), 4);
    @(negedge CLK);
    Branch_taken = 0;
    #1;
    check_val("zw_fzb",   32'(a_freeze_back), 0);
    check_val("zw_flush", 32'(a_flush_front), 0);
    check_val("zw_stall", 32'(a_stall_count), 4);

    // Timeout with MEM_TIMEOUT=3
    @(negedge CLK);
    do_reset();
    Mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_val("to_err_pre", 32'(b_mem_err), 0);
      check_val("to_fzf",     32'(b_freeze_front), 1);
      @(negedge CLK);
    end
    #1;
    check_val("to_err",   32'(b_mem_err), 1);
    check_val("to_fzf_e", 32'(b_freeze_front), 1);
    check_val("to_fzb_e", 32'(b_freeze_back), 1);
    mem_ready = 1;
    #1;
    check_val("to_err_hold_fzb", 32'(b_freeze_back), 1);
    @(negedge CLK);
    check_val("to_err_sticky", 32'(b_mem_err), 1);
    mem_ready = 0;
    #2;
    RST = 1'b0;
    #1;
    check_val("ar_err",   32'(b_mem_err), 0);
    check_val("ar_stall", 32'(b_stall_count), 0);
    check_val("ar_fzb_b", 32'(b_freeze_back), 0);
    check_val("ar_fzb_a", 32'(a_freeze_back), 0);
    @(negedge CLK);
    RST = 1'b1;
    mem_ready = 1;
    #1;
    check_val("ar_run_fzb", 32'(b_freeze_back), 0);

    // Stall counter saturation with CNT_W=4
    @(negedge CLK);
    do_reset();
    Mem_Dest = 4'd5; Mem_WB_EN = 1; src1 = 4'd5;
    repeat (14) @(negedge CLK);
    check_val("sat_14", 32'(b_stall_count), 14);
    repeat (6) @(negedge CLK);
    check_val("sat_20",     32'(b_stall_count), 15);
    check_val("sat_hazard", 32'(b_hazard), 1);
    repeat (2) @(negedge CLK);
    check_val("sat_hold",   32'(b_stall_count), 15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
